// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register built as a two-entry skid buffer.
// in_ready is decoded from registered state only, so there is no out_ready -> in_ready path.
module mem_wb_pipe #(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ZERO_REG_KILL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] w_reg_addr_in,
    input  logic [DATA_W-1:0] w_reg_data_in,
    input  logic              w_reg_en_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] w_reg_addr_out,
    output logic [DATA_W-1:0] w_reg_data_out,
    output logic              w_reg_en_out,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {StEmpty, StHalf, StFull} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              main_en_q, main_en_d, skid_en_q, skid_en_d;

    logic in_fire, out_fire, cap_en;

    // Writes to the zero register are neutralised at capture, not at the output.
    assign cap_en = w_reg_en_in &
                    ~((ZERO_REG_KILL != 0) && (w_reg_addr_in == '0));

    always_comb begin
        in_ready  = (state_q != StFull);
        out_valid = (state_q != StEmpty);
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StHalf:  occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
        w_reg_addr_out = main_addr_q;
        w_reg_data_out = main_data_q;
        w_reg_en_out   = main_en_q & out_valid;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_addr_d = main_addr_q;
        main_data_d = main_data_q;
        main_en_d   = main_en_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        skid_en_d   = skid_en_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_addr_d = w_reg_addr_in;
                        main_data_d = w_reg_data_in;
                        main_en_d   = cap_en;
                        state_d     = StHalf;
                    end
                end
                StHalf: begin
                    if (in_fire && out_fire) begin
                        main_addr_d = w_reg_addr_in;
                        main_data_d = w_reg_data_in;
                        main_en_d   = cap_en;
                    end else if (in_fire) begin
                        skid_addr_d = w_reg_addr_in;
                        skid_data_d = w_reg_data_in;
                        skid_en_d   = cap_en;
                        state_d     = StFull;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_addr_d = skid_addr_q;
                        main_data_d = skid_data_q;
                        main_en_d   = skid_en_q;
                        state_d     = StHalf;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_addr_q <= '0;
            main_data_q <= '0;
            main_en_q   <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            skid_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_addr_q <= main_addr_d;
            main_data_q <= main_data_d;
            main_en_q   <= main_en_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            skid_en_q   <= skid_en_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus random stress
// against a FIFO-queue reference model.
module tb_mem_wb_pipe;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [AW-1:0] w_reg_addr_in, w_reg_addr_out;
    logic [DW-1:0] w_reg_data_in, w_reg_data_out;
    logic          w_reg_en_in, w_reg_en_out;
    logic [1:0]    occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          e;
    } entry_t;
    entry_t q[$];

    mem_wb_pipe #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG_KILL(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .w_reg_addr_in  (w_reg_addr_in),
        .w_reg_data_in  (w_reg_data_in),
        .w_reg_en_in    (w_reg_en_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .w_reg_addr_out (w_reg_addr_out),
        .w_reg_data_out (w_reg_data_out),
        .w_reg_en_out   (w_reg_en_out),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Reference: a bounded FIFO of capacity two; pop before push each edge.
    task automatic model_edge();
        int sz;
        entry_t ent;
        sz = q.size();
        if (flush) begin
            q.delete();
        end else begin
            if (out_ready && sz > 0) void'(q.pop_front());
            if (in_valid && sz < 2) begin
                ent.a = w_reg_addr_in;
                ent.d = w_reg_data_in;
                ent.e = w_reg_en_in && (w_reg_addr_in != 0);
                q.push_back(ent);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic e, input logic ordy, input logic fl);
        in_valid = v; w_reg_addr_in = a; w_reg_data_in = d; w_reg_en_in = e;
        out_ready = ordy; flush = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #3;
        total += 5;
        if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_iready got=%b exp=1", in_ready); end
        if (w_reg_en_out !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", w_reg_en_out); end
        if ({w_reg_addr_out, w_reg_data_out} !== '0) begin
            bad++; $display("FAIL reset_payload got=%h/%h exp=0/0", w_reg_addr_out, w_reg_data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, AW'(i), DW'(i), 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            if (i > 1) begin
                total++;
                if (!(out_valid === 1'b1 && w_reg_data_out === DW'(i - 1) && occupancy === 2'd1
                      && in_ready === 1'b1 && w_reg_en_out === 1'b1)) begin
                    bad++;
                    $display("FAIL stream_%0d got v=%b d=%0d occ=%0d ir=%b en=%b exp v=1 d=%0d occ=1 ir=1 en=1",
                             i, out_valid, w_reg_data_out, occupancy, in_ready, w_reg_en_out, i - 1);
                end
            end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (w_reg_data_out !== 32'd8 || out_valid !== 1'b1) begin
            bad++; $display("FAIL stream_last got v=%b d=%0d exp v=1 d=8", out_valid, w_reg_data_out);
        end
        tick();
        @(negedge clk);
        total++;
        if (occupancy !== 2'd0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 5'd1, 32'hA, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd2, 32'hB, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd3, 32'hC, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || w_reg_data_out !== 32'hA) begin
            bad++; $display("FAIL bp_full got occ=%0d ir=%b d=%h exp occ=2 ir=0 d=a",
                            occupancy, in_ready, w_reg_data_out);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (w_reg_data_out !== 32'hA || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_a got v=%b d=%h exp v=1 d=a", out_valid, w_reg_data_out);
        end
        tick();
        @(negedge clk);
        total++;
        if (w_reg_data_out !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_b got d=%h occ=%0d ir=%b exp d=b occ=1 ir=1",
                            w_reg_data_out, occupancy, in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (w_reg_data_out !== 32'hC || out_valid !== 1'b1 || w_reg_addr_out !== 5'd3) begin
            bad++; $display("FAIL bp_c got v=%b a=%0d d=%h exp v=1 a=3 d=c",
                            out_valid, w_reg_addr_out, w_reg_data_out);
        end
        tick();
        @(negedge clk);
        total++;
        if (occupancy !== 2'd0) begin bad++; $display("FAIL bp_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || w_reg_en_out !== 1'b0 || w_reg_data_out !== 32'hDEADBEEF) begin
            bad++; $display("FAIL zero_reg got v=%b en=%b d=%h exp v=1 en=0 d=deadbeef",
                            out_valid, w_reg_en_out, w_reg_data_out);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd7, 32'h111, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd8, 32'h222, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd9, 32'h333, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        total++;
        if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre got=%0d exp=2", occupancy); end
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || w_reg_en_out !== 1'b0) begin
            bad++; $display("FAIL flush_post got occ=%0d v=%b ir=%b en=%b exp occ=0 v=0 ir=1 en=0",
                            occupancy, out_valid, in_ready, w_reg_en_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost_%0d got v=%b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd4, 32'h444, 1'b1, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (occupancy !== 2'd1) begin bad++; $display("FAIL areset_pre got=%0d exp=1", occupancy); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || w_reg_en_out !== 1'b0 || in_ready !== 1'b1
            || w_reg_addr_out !== '0 || w_reg_data_out !== '0) begin
            bad++; $display("FAIL areset_now got occ=%0d v=%b en=%b ir=%b a=%0d d=%h exp all 0, ir=1",
                            occupancy, out_valid, w_reg_en_out, in_ready, w_reg_addr_out, w_reg_data_out);
        end
        #1 rst_n = 1'b1;
        q.delete();
        drive(1'b1, 5'd5, 32'h55, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || w_reg_addr_out !== 5'd5 || w_reg_en_out !== 1'b1) begin
            bad++; $display("FAIL areset_push got v=%b a=%0d en=%b exp v=1 a=5 en=1",
                            out_valid, w_reg_addr_out, w_reg_en_out);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_stress();
        int sbad;
        sbad = 0;
        for (int c = 0; c < 10000 && sbad < 20; c++) begin
            drive(($urandom_range(0, 9) < 6), AW'($urandom), $urandom, 1'($urandom),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
            @(negedge clk);
            total++;
            if (occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2)
                || out_valid !== (q.size() > 0)) begin
                bad++; sbad++;
                $display("FAIL stress_ctl_%0d got occ=%0d ir=%b v=%b exp occ=%0d",
                         c, occupancy, in_ready, out_valid, q.size());
            end
            if (q.size() > 0) begin
                total++;
                if (w_reg_addr_out !== q[0].a || w_reg_data_out !== q[0].d || w_reg_en_out !== q[0].e) begin
                    bad++; sbad++;
                    $display("FAIL stress_head_%0d got a=%0d d=%h en=%b exp a=%0d d=%h en=%b", c,
                             w_reg_addr_out, w_reg_data_out, w_reg_en_out, q[0].a, q[0].d, q[0].e);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_zero_reg();
        test_flush();
        test_async_reset();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
